oam_dma_arbiter: RTL and testbench

//  Owns the write port of oam_memory and shares it between CPU single-halfword writes
//  and a 128-halfword DMA burst copied from a source memory (NES-style OAMDMA).

---
 rtl/oam_dma_arbiter.sv | 102 ++++++++++
 tb/tb_oam_dma_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter.sv
// OAM write-port arbiter: CPU single-halfword writes vs. a 128-halfword DMA burst from source RAM.
// Optional `OAM_DMA_IRQ_EN adds a sticky dma_irq with dma_irq_ack.
module oam_dma_arbiter #(
  parameter int OAM_WORDS  = 128,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 16,
  parameter int SRC_ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_write_enable,
  input  logic [ADDR_W-1:0]     cpu_write_addr,
  input  logic [DATA_W-1:0]     cpu_write_data,
  output logic                  cpu_write_ready,
  input  logic                  dma_start,
  input  logic [SRC_ADDR_W-1:0] dma_src_base,
  output logic                  src_read_en,
  output logic [SRC_ADDR_W-1:0] src_read_addr,
  input  logic [DATA_W-1:0]     src_read_data,
  output logic                  oam_write_enable,
  output logic [ADDR_W-1:0]     oam_write_addr,
  output logic [DATA_W-1:0]     oam_write_data,
  output logic                  dma_busy,
`ifdef OAM_DMA_IRQ_EN
  output logic                  dma_irq,
  input  logic                  dma_irq_ack,
`endif
  output logic                  dma_done
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(OAM_WORDS - 1);

  state_t                state;
  logic [ADDR_W-1:0]     count;
  logic [SRC_ADDR_W-1:0] src_addr;
  logic                  cpu_wr_q;
  logic [ADDR_W-1:0]     cpu_addr_q;
  logic [DATA_W-1:0]     cpu_data_q;
  logic                  cpu_accept;
  logic                  run_last;

  assign cpu_accept = cpu_write_enable && (state == IDLE);
  assign run_last   = (state == RUN) && (count == LAST);

  // src_addr always points at the read being issued this cycle; it wraps modulo 2^SRC_ADDR_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      src_addr   <= '0;
      cpu_wr_q   <= 1'b0;
      cpu_addr_q <= '0;
      cpu_data_q <= '0;
    end else begin
      cpu_wr_q <= cpu_accept;
      if (cpu_accept) begin
        cpu_addr_q <= cpu_write_addr;
        cpu_data_q <= cpu_write_data;
      end
      unique case (state)
        IDLE: if (dma_start) begin
          state    <= PRIME;
          src_addr <= dma_src_base;
          count    <= '0;
        end
        PRIME: begin
          state    <= RUN;
          src_addr <= src_addr + SRC_ADDR_W'(1);
        end
        RUN: begin
          src_addr <= src_addr + SRC_ADDR_W'(1);
          count    <= count + ADDR_W'(1);
          if (count == LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OAM_DMA_IRQ_EN
  // Set beats ack when both land in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             dma_irq <= 1'b0;
    else if (run_last)     dma_irq <= 1'b1;
    else if (dma_irq_ack)  dma_irq <= 1'b0;
  end
`endif

  assign cpu_write_ready = (state == IDLE);
  assign dma_busy        = (state != IDLE);
  assign dma_done        = run_last;
  assign src_read_en     = (state == PRIME) || ((state == RUN) && (count != LAST));
  assign src_read_addr   = src_addr;

  // A CPU write can only land in IDLE or PRIME, so it never collides with a RUN write.
  assign oam_write_enable = cpu_wr_q || (state == RUN);
  assign oam_write_addr   = (state == RUN) ? count : cpu_addr_q;
  assign oam_write_data   = (state == RUN) ? src_read_data : cpu_data_q;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: random + directed stimulus against a cycle-offset transaction model.
module tb_oam_dma_arbiter;
  localparam int OAM_WORDS = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_write_enable;
  logic [6:0]  cpu_write_addr;
  logic [15:0] cpu_write_data;
  logic        cpu_write_ready;
  logic        dma_start;
  logic [15:0] dma_src_base;
  logic        src_read_en;
  logic [15:0] src_read_addr;
  logic [15:0] src_read_data;
  logic        oam_write_enable;
  logic [6:0]  oam_write_addr;
  logic [15:0] oam_write_data;
  logic        dma_busy;
  logic        dma_done;
`ifdef OAM_DMA_IRQ_EN
  logic        dma_irq;
  logic        dma_irq_ack;
  bit          irq_exp;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Model: a burst is identified only by its start cycle S; cycle offset p = t - S
  // gives PRIME at p==1, the k-th OAM write at p==k+2, done at p==OAM_WORDS+1.
  int          t = 0;
  int          S = -1;
  logic [15:0] mbase;
  bit          cpu_pend;
  logic [6:0]  cpu_a;
  logic [15:0] cpu_d;
  bit          rd_pend;
  logic [15:0] rd_addr;

  always #5 clk = ~clk;

  oam_dma_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_write_enable(cpu_write_enable), .cpu_write_addr(cpu_write_addr),
    .cpu_write_data(cpu_write_data), .cpu_write_ready(cpu_write_ready),
    .dma_start(dma_start), .dma_src_base(dma_src_base),
    .src_read_en(src_read_en), .src_read_addr(src_read_addr), .src_read_data(src_read_data),
    .oam_write_enable(oam_write_enable), .oam_write_addr(oam_write_addr),
    .oam_write_data(oam_write_data), .dma_busy(dma_busy),
`ifdef OAM_DMA_IRQ_EN
    .dma_irq(dma_irq), .dma_irq_ack(dma_irq_ack),
`endif
    .dma_done(dma_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  function automatic bit done_cycle();
    return (S >= 0) && (t - S == OAM_WORDS + 1);
  endfunction

  // Called just after a negedge with inputs already set; returns at the next negedge.
  task automatic step();
    int          p;
    bit          idle, run, exp_rd, exp_we, exp_done;
    logic [6:0]  exp_a;
    logic [15:0] exp_d, exp_ra;
    src_read_data = rd_pend ? (rd_addr ^ 16'h5A5A) : 16'($urandom);
    #1;
    idle     = (S < 0);
    p        = t - S;
    run      = !idle && p >= 2;
    exp_rd   = !idle && p <= OAM_WORDS;
    exp_ra   = 16'(mbase + 16'(p - 1));
    exp_done = !idle && p == OAM_WORDS + 1;
    exp_we   = run || cpu_pend;
    exp_a    = run ? 7'(p - 2) : cpu_a;
    exp_d    = run ? (16'(mbase + 16'(p - 2)) ^ 16'h5A5A) : cpu_d;

    chk("ready", 64'(cpu_write_ready), 64'(idle));
    chk("busy", 64'(dma_busy), 64'(!idle));
    chk("done", 64'(dma_done), 64'(exp_done));
    chk("src_en", 64'(src_read_en), 64'(exp_rd));
    if (exp_rd) chk("src_addr", 64'(src_read_addr), 64'(exp_ra));
    chk("oam_we", 64'(oam_write_enable), 64'(exp_we));
    if (exp_we) begin
      chk("oam_addr", 64'(oam_write_addr), 64'(exp_a));
      chk("oam_data", 64'(oam_write_data), 64'(exp_d));
    end
`ifdef OAM_DMA_IRQ_EN
    chk("irq", 64'(dma_irq), 64'(irq_exp));
    if (exp_done)         irq_exp = 1'b1;
    else if (dma_irq_ack) irq_exp = 1'b0;
`endif

    rd_pend  = src_read_en;
    rd_addr  = src_read_addr;
    cpu_pend = idle && cpu_write_enable;
    cpu_a    = cpu_write_addr;
    cpu_d    = cpu_write_data;
    if (exp_done) S = -1;
    if (idle && dma_start) begin
      S     = t;
      mbase = dma_src_base;
    end
    t++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_ready", 64'(cpu_write_ready), 64'd1);
    chk("rst_outs", 64'({src_read_en, src_read_addr, oam_write_enable, oam_write_addr,
                         oam_write_data, dma_busy, dma_done}), 64'd0);
`ifdef OAM_DMA_IRQ_EN
    chk("rst_irq", 64'(dma_irq), 64'd0);
    irq_exp = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    S        = -1;
    cpu_pend = 1'b0;
    rd_pend  = 1'b0;
  endtask

  task automatic quiet();
    cpu_write_enable = 1'b0;
    dma_start        = 1'b0;
`ifdef OAM_DMA_IRQ_EN
    dma_irq_ack      = 1'b0;
`endif
  endtask

  initial begin
    reset          = 1'b1;
    cpu_write_addr = '0;
    cpu_write_data = '0;
    dma_src_base   = '0;
    src_read_data  = '0;
    quiet();
    @(negedge clk);
    do_reset();

    // Single CPU write while idle
    cpu_write_enable = 1'b1; cpu_write_addr = 7'h05; cpu_write_data = 16'hBEEF;
    step();
    quiet();
    step();
    step();

    // Burst from 0x0200, CPU write held throughout, second start mid-burst ignored
    dma_start = 1'b1; dma_src_base = 16'h0200;
    cpu_write_enable = 1'b1;
    step();
    for (int i = 0; i < OAM_WORDS + 6; i++) begin
      dma_start      = (i == 60);
      dma_src_base   = 16'($urandom);
      cpu_write_addr = 7'($urandom);
      cpu_write_data = 16'($urandom);
      step();
    end
    quiet();
    step();

    // Source address wrap from 0xFFC0
    dma_start = 1'b1; dma_src_base = 16'hFFC0;
    step();
    dma_start = 1'b0;
    for (int i = 0; i < OAM_WORDS + 4; i++) step();

    // Reset at count 40
    dma_start = 1'b1; dma_src_base = 16'h1234;
    step();
    dma_start = 1'b0;
    for (int i = 0; i < 41; i++) step();
    do_reset();
    for (int i = 0; i < OAM_WORDS + 4; i++) step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cpu_write_enable = 1'($urandom);
      cpu_write_addr   = 7'($urandom);
      cpu_write_data   = 16'($urandom);
      dma_start        = ($urandom_range(0, 39) == 0);
      dma_src_base     = 16'($urandom);
`ifdef OAM_DMA_IRQ_EN
      dma_irq_ack      = ($urandom_range(0, 7) == 0);
`endif
      step();
    end
    quiet();
    for (int i = 0; i < OAM_WORDS + 4; i++) step();

`ifdef OAM_DMA_IRQ_EN
    // Ack coinciding with set, then a plain ack
    dma_irq_ack = 1'b1;
    step();
    dma_irq_ack = 1'b0;
    dma_start = 1'b1; dma_src_base = 16'h0040;
    step();
    dma_start = 1'b0;
    for (int i = 0; i < OAM_WORDS + 4; i++) begin
      dma_irq_ack = done_cycle();
      step();
    end
    dma_irq_ack = 1'b0;
    step();
    dma_irq_ack = 1'b1;
    step();
    dma_irq_ack = 1'b0;
    step();
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
